mem_access_arbiter: RTL

//  Two-requester round-robin arbiter and sequencer for the single-port 64x15 sample RAM.

---
 rtl/mem_access_arbiter_if.sv | 45 ++++
 rtl/mem_access_arbiter.sv | 105 ++++++++++
 2 files changed

// File: rtl/mem_access_arbiter_if.sv
// rtl/mem_access_arbiter_if.sv - requester, response and RAM signal bundle for mem_access_arbiter
interface mem_access_arbiter_if #(
    parameter int AW = 6,
    parameter int DW = 15
);
    logic          req0_valid;
    logic          req0_ready;
    logic          req0_rw_n;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          rsp0_valid;
    logic [DW-1:0] rsp0_rdata;

    logic          req1_valid;
    logic          req1_ready;
    logic          req1_rw_n;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp1_valid;
    logic [DW-1:0] rsp1_rdata;

    logic          mem_cs;
    logic          mem_rw_n;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req0_valid, req0_rw_n, req0_addr, req0_wdata,
        input  req1_valid, req1_rw_n, req1_addr, req1_wdata,
        input  mem_rdata,
        output req0_ready, rsp0_valid, rsp0_rdata,
        output req1_ready, rsp1_valid, rsp1_rdata,
        output mem_cs, mem_rw_n, mem_addr, mem_wdata
    );

    modport master (
        output req0_valid, req0_rw_n, req0_addr, req0_wdata,
        output req1_valid, req1_rw_n, req1_addr, req1_wdata,
        output mem_rdata,
        input  req0_ready, rsp0_valid, rsp0_rdata,
        input  req1_ready, rsp1_valid, rsp1_rdata,
        input  mem_cs, mem_rw_n, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_access_arbiter.sv
// rtl/mem_access_arbiter.sv - two-requester round-robin arbiter and sequencer for the single-port sample RAM
module mem_access_arbiter #(
    parameter int AW     = 6,
    parameter int DW     = 15,
    parameter int RD_LAT = 1
) (
    input  logic                CLK,
    input  logic                RST_N,
    mem_access_arbiter_if.slave bus,
    output logic                busy,
    output logic                last_grant
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t        state;
    state_t        state_nx;
    logic          win;
    logic          accept;
    logic          sel_rw_n;
    logic [AW-1:0] sel_addr;
    logic [DW-1:0] sel_wdata;
    logic          cap_id;
    logic          cap_rw_n;
    logic [2:0]    wait_cnt;

    // A lone requester always wins; on a tie the one not served last time wins.
    always_comb begin
        win = 1'b0;
        if (bus.req0_valid && bus.req1_valid) begin
            win = ~last_grant;
        end else if (bus.req1_valid) begin
            win = 1'b1;
        end
    end

    assign accept         = (state == IDLE) && (bus.req0_valid || bus.req1_valid);
    assign bus.req0_ready = (state == IDLE) && bus.req0_valid && !win;
    assign bus.req1_ready = (state == IDLE) && bus.req1_valid && win;
    assign sel_rw_n       = win ? bus.req1_rw_n  : bus.req0_rw_n;
    assign sel_addr       = win ? bus.req1_addr  : bus.req0_addr;
    assign sel_wdata      = win ? bus.req1_wdata : bus.req0_wdata;
    assign busy           = (state != IDLE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (accept) state_nx = ISSUE;
            ISSUE:   state_nx = cap_rw_n ? WAIT : DONE;
            WAIT:    if (wait_cnt == 3'd0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            last_grant     <= 1'b1;
            cap_id         <= 1'b0;
            cap_rw_n       <= 1'b1;
            wait_cnt       <= 3'd0;
            bus.mem_cs     <= 1'b0;
            bus.mem_rw_n   <= 1'b1;
            bus.mem_addr   <= '0;
            bus.mem_wdata  <= '0;
            bus.rsp0_valid <= 1'b0;
            bus.rsp1_valid <= 1'b0;
            bus.rsp0_rdata <= '0;
            bus.rsp1_rdata <= '0;
        end else begin
            // Strobe is high only during ISSUE; address and data hold afterwards.
            bus.mem_cs   <= accept;
            bus.mem_rw_n <= accept ? sel_rw_n : 1'b1;
            if (accept) begin
                last_grant    <= win;
                cap_id        <= win;
                cap_rw_n      <= sel_rw_n;
                bus.mem_addr  <= sel_addr;
                bus.mem_wdata <= sel_wdata;
            end

            if (state == ISSUE) begin
                wait_cnt <= 3'(RD_LAT - 1);
            end else if (state == WAIT) begin
                wait_cnt <= wait_cnt - 3'd1;
            end

            bus.rsp0_valid <= (state_nx == DONE) && !cap_id;
            bus.rsp1_valid <= (state_nx == DONE) && cap_id;
            if (state_nx == DONE && !cap_id) begin
                bus.rsp0_rdata <= cap_rw_n ? bus.mem_rdata : '0;
            end
            if (state_nx == DONE && cap_id) begin
                bus.rsp1_rdata <= cap_rw_n ? bus.mem_rdata : '0;
            end
        end
    end
endmodule
